// File: rtl/pp_6_pkg.sv
// Shared types and constants for the pp_6 a-then-b sequence detector.
package pp_6_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GOT_A = 2'd1,
    DET   = 2'd2
  } state_t;

endpackage

// File: rtl/pp_6_if.sv
// Sequence-detector signal bundle. a/b are sampled on every rising clock
// (no valid/ready handshake); y is the registered detect flag.
interface pp_6_if;
  logic a;
  logic b;
  logic y;

  modport master (output a, output b, input  y);
  modport slave  (input  a, input  b, output y);
endinterface

// File: rtl/pp_6_hold_cnt.sv
// Retriggerable hold counter: load wins, otherwise count down and stop at 0.
// o_nz is registered so the detect flag never sees a combinational input path.
module pp_6_hold_cnt
  import pp_6_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_nz
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_nz;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_load) begin
      w_cnt_nxt = i_load_val;
    end else if (r_cnt != '0) begin
      w_cnt_nxt = r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_nz  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_nz  <= (w_cnt_nxt != '0);
    end
  end

  assign o_nz = r_nz;

endmodule

// File: rtl/pp_6.sv
// a-then-b sequence detector with a HOLD_CYCLES-wide registered detect pulse.
// Optional macro PP_6_STICKY_EN latches y high after the first detection until reset.
module pp_6
  import pp_6_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic   a,
  input  logic   b,
  output logic   y,
  input  logic   Rst,
  input  logic   Clk,
  output state_t o_dbg_state
);

  localparam logic [CNT_W-1:0] LP_HOLD = CNT_W'(HOLD_CYCLES);

  state_t r_state;
  state_t w_state_nxt;
  logic   w_load;
  logic   w_nz;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // In GOT_A, b outranks a so that a=b=1 completes a detection.
  always_comb begin
    w_state_nxt = IDLE;
    case (r_state)
      IDLE:    w_state_nxt = a ? GOT_A : IDLE;
      GOT_A: begin
        if (b)      w_state_nxt = DET;
        else if (a) w_state_nxt = GOT_A;
        else        w_state_nxt = IDLE;
      end
      DET:     w_state_nxt = a ? GOT_A : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_load      = (w_state_nxt == DET);
  assign o_dbg_state = r_state;

  pp_6_hold_cnt u_hold_cnt (
    .clk        (Clk),
    .rst        (Rst),
    .i_load     (w_load),
    .i_load_val (LP_HOLD),
    .o_nz       (w_nz)
  );

`ifdef PP_6_STICKY_EN
  logic r_sticky;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_sticky <= 1'b0;
    end else if (w_nz) begin
      r_sticky <= 1'b1;
    end
  end

  assign y = w_nz | r_sticky;
`else
  assign y = w_nz;
`endif

endmodule

// File: tb/tb_pp_6.sv
// Bench for pp_6: two instances (HOLD_CYCLES=1 and 3) share stimulus and are
// compared against a sequence-rule model kept as plain integers.
module tb_pp_6;
  import pp_6_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t st1, st3;
  int     n_checks = 0;
  int     n_errors = 0;

  always #5 clk = ~clk;

  pp_6_if bus1();
  pp_6_if bus3();

  pp_6 #(.HOLD_CYCLES(1)) dut1 (
    .a(bus1.a), .b(bus1.b), .y(bus1.y), .Rst(rst), .Clk(clk), .o_dbg_state(st1)
  );
  pp_6 #(.HOLD_CYCLES(3)) dut3 (
    .a(bus3.a), .b(bus3.b), .y(bus3.y), .Rst(rst), .Clk(clk), .o_dbg_state(st3)
  );

  // Model: "armed" means the last sampled a=1 did not complete a detection.
  bit m_armed, m_det, m_stk1, m_stk3;
  int m_hold1, m_hold3;

  function void model_reset();
    m_armed = 0; m_det = 0; m_stk1 = 0; m_stk3 = 0; m_hold1 = 0; m_hold3 = 0;
  endfunction

  function void model_edge(input bit a, input bit b);
    m_det   = m_armed && b;
    m_armed = a && !m_det;
    m_hold1 = m_det ? 1 : ((m_hold1 > 0) ? m_hold1 - 1 : 0);
    m_hold3 = m_det ? 3 : ((m_hold3 > 0) ? m_hold3 - 1 : 0);
    if (m_hold1 > 0) m_stk1 = 1;
    if (m_hold3 > 0) m_stk3 = 1;
  endfunction

  function bit exp_y1();
`ifdef PP_6_STICKY_EN
    return (m_hold1 > 0) || m_stk1;
`else
    return (m_hold1 > 0);
`endif
  endfunction

  function bit exp_y3();
`ifdef PP_6_STICKY_EN
    return (m_hold3 > 0) || m_stk3;
`else
    return (m_hold3 > 0);
`endif
  endfunction

  function state_t exp_state();
    return m_det ? DET : (m_armed ? GOT_A : IDLE);
  endfunction

  task automatic step(input bit a, input bit b);
    bus1.a = a; bus1.b = b; bus3.a = a; bus3.b = b;
    @(posedge clk);
    if (rst) model_reset(); else model_edge(a, b);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    bus1.a = 0; bus1.b = 0; bus3.a = 0; bus3.b = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus1.a = 0; bus1.b = 0; bus3.a = 0; bus3.b = 0;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    n_checks++; if (bus1.y !== 1'b0) begin n_errors++; $display("FAIL reset_y1: got %0b want 0", bus1.y); end
    n_checks++; if (bus3.y !== 1'b0) begin n_errors++; $display("FAIL reset_y3: got %0b want 0", bus3.y); end
    n_checks++; if (st1 !== IDLE) begin n_errors++; $display("FAIL reset_state: got %0d want %0d", st1, IDLE); end
    rst = 1'b0;
    step(0, 1);
    n_checks++; if (bus1.y !== 1'b0) begin n_errors++; $display("FAIL reset_b_only_y: got %0b want 0", bus1.y); end
    n_checks++; if (st1 !== IDLE) begin n_errors++; $display("FAIL reset_b_only_state: got %0d want %0d", st1, IDLE); end
  endtask

  task automatic test_basic();
    do_reset();
    step(1, 1);
    n_checks++; if (st1 !== GOT_A) begin n_errors++; $display("FAIL basic_n_state: got %0d want %0d", st1, GOT_A); end
    n_checks++; if (bus1.y !== 1'b0) begin n_errors++; $display("FAIL basic_n_y: got %0b want 0", bus1.y); end
    step(1, 1);
    n_checks++; if (st1 !== DET) begin n_errors++; $display("FAIL basic_n1_state: got %0d want %0d", st1, DET); end
    n_checks++; if (bus1.y !== 1'b1) begin n_errors++; $display("FAIL basic_n1_y: got %0b want 1", bus1.y); end
    step(1, 1);
    n_checks++; if (st1 !== GOT_A) begin n_errors++; $display("FAIL basic_n2_state: got %0d want %0d", st1, GOT_A); end
    n_checks++; if (bus1.y !== exp_y1()) begin n_errors++; $display("FAIL basic_n2_y1: got %0b want %0b", bus1.y, exp_y1()); end
    n_checks++; if (bus3.y !== exp_y3()) begin n_errors++; $display("FAIL basic_n2_y3: got %0b want %0b", bus3.y, exp_y3()); end
  endtask

  task automatic test_no_detect();
    do_reset();
    step(1, 0);
    n_checks++; if (st1 !== GOT_A) begin n_errors++; $display("FAIL nodet_gota: got %0d want %0d", st1, GOT_A); end
    step(0, 0);
    n_checks++; if (st1 !== IDLE) begin n_errors++; $display("FAIL nodet_idle: got %0d want %0d", st1, IDLE); end
    n_checks++; if (bus1.y !== 1'b0) begin n_errors++; $display("FAIL nodet_y: got %0b want 0", bus1.y); end
    for (int i = 0; i < 3; i++) begin
      step(0, 1);
      n_checks++; if (bus1.y !== 1'b0 || bus3.y !== 1'b0) begin n_errors++; $display("FAIL nodet_b_alone: got y1=%0b y3=%0b want 0", bus1.y, bus3.y); end
      n_checks++; if (st1 !== IDLE) begin n_errors++; $display("FAIL nodet_b_state: got %0d want %0d", st1, IDLE); end
    end
  endtask

  task automatic test_hold3();
    int highs;
    do_reset();
    step(1, 0);
    step(0, 1);
    highs = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step(0, 0);
      highs += int'(bus3.y);
      n_checks++; if (bus3.y !== exp_y3()) begin n_errors++; $display("FAIL hold3_y c%0d: got %0b want %0b", i, bus3.y, exp_y3()); end
    end
`ifdef PP_6_STICKY_EN
    n_checks++; if (highs != 6) begin n_errors++; $display("FAIL hold3_len: got %0d want 6", highs); end
`else
    n_checks++; if (highs != 3) begin n_errors++; $display("FAIL hold3_len: got %0d want 3", highs); end
`endif
    do_reset();
    step(1, 0);
    step(0, 1);
    step(1, 0);
    n_checks++; if (bus3.y !== 1'b1) begin n_errors++; $display("FAIL retrig_mid: got %0b want 1", bus3.y); end
    step(0, 1);
    highs = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step(0, 0);
      highs += int'(bus3.y);
      n_checks++; if (bus3.y !== exp_y3()) begin n_errors++; $display("FAIL retrig_y c%0d: got %0b want %0b", i, bus3.y, exp_y3()); end
    end
`ifdef PP_6_STICKY_EN
    n_checks++; if (highs != 6) begin n_errors++; $display("FAIL retrig_len: got %0d want 6", highs); end
`else
    n_checks++; if (highs != 3) begin n_errors++; $display("FAIL retrig_len: got %0d want 3", highs); end
`endif
  endtask

  task automatic test_toggle();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1, 1);
      n_checks++; if (bus1.y !== exp_y1()) begin n_errors++; $display("FAIL toggle_y c%0d: got %0b want %0b", i, bus1.y, exp_y1()); end
      n_checks++; if (st1 !== exp_state()) begin n_errors++; $display("FAIL toggle_state c%0d: got %0d want %0d", i, st1, exp_state()); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1, 0);
    step(0, 1);
    n_checks++; if (bus1.y !== 1'b1 || bus3.y !== 1'b1) begin n_errors++; $display("FAIL arst_pre: got y1=%0b y3=%0b want 1", bus1.y, bus3.y); end
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++; if (bus1.y !== 1'b0 || bus3.y !== 1'b0) begin n_errors++; $display("FAIL arst_mid: got y1=%0b y3=%0b want 0", bus1.y, bus3.y); end
    n_checks++; if (st1 !== IDLE) begin n_errors++; $display("FAIL arst_state: got %0d want %0d", st1, IDLE); end
    for (int i = 0; i < 3; i++) begin
      step(1, 1);
      n_checks++; if (bus3.y !== 1'b0 || st3 !== IDLE) begin n_errors++; $display("FAIL arst_hold c%0d: got y=%0b st=%0d want 0/%0d", i, bus3.y, st3, IDLE); end
    end
    rst = 1'b0;
    step(1, 1);
    n_checks++; if (st1 !== GOT_A) begin n_errors++; $display("FAIL arst_release: got %0d want %0d", st1, GOT_A); end
  endtask

  task automatic test_sticky();
    do_reset();
    step(1, 0);
    step(0, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0);
      n_checks++; if (bus1.y !== exp_y1()) begin n_errors++; $display("FAIL sticky_y1 c%0d: got %0b want %0b", i, bus1.y, exp_y1()); end
    end
`ifdef PP_6_STICKY_EN
    n_checks++; if (bus1.y !== 1'b1) begin n_errors++; $display("FAIL sticky_held: got %0b want 1", bus1.y); end
`else
    n_checks++; if (bus1.y !== 1'b0) begin n_errors++; $display("FAIL sticky_off: got %0b want 0", bus1.y); end
`endif
    do_reset();
    n_checks++; if (bus1.y !== 1'b0) begin n_errors++; $display("FAIL sticky_clear: got %0b want 0", bus1.y); end
  endtask

  task automatic test_random();
    bit ra, rb;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 63) == 0) begin
        rst = 1'b1;
        model_reset();
        step(ra, rb);
        rst = 1'b0;
      end else begin
        step(ra, rb);
      end
      n_checks++; if (bus1.y !== exp_y1()) begin n_errors++; $display("FAIL rand_y1 c%0d: got %0b want %0b", i, bus1.y, exp_y1()); end
      n_checks++; if (bus3.y !== exp_y3()) begin n_errors++; $display("FAIL rand_y3 c%0d: got %0b want %0b", i, bus3.y, exp_y3()); end
      n_checks++; if (st1 !== exp_state() || st3 !== exp_state()) begin n_errors++; $display("FAIL rand_state c%0d: got %0d/%0d want %0d", i, st1, st3, exp_state()); end
    end
  endtask

  initial begin
    bus1.a = 0; bus1.b = 0; bus3.a = 0; bus3.b = 0;
    model_reset();
    #1;
    test_reset();
    test_basic();
    test_no_detect();
    test_hold3();
    test_toggle();
    test_async_reset();
    test_sticky();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
